// File: rtl/io_port_select_pkg.sv
// Shared types and constants for the IO board port selector.
// Holds the FSM state enum, the wait counter width and the select-width helper.
package io_port_select_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACTIVE,
    S_RELEASE
  } state_t;

  localparam int CNT_W = 4;

  function automatic int n_sel(input int sel_bits);
    return 1 << sel_bits;
  endfunction

endpackage

// File: rtl/io_port_select_onehot_decoder.sv
// Combinational binary-to-one-hot decoder; all outputs low when not enabled.
module onehot_decoder
  import io_port_select_pkg::*;
#(
  parameter int SEL_BITS = 4
) (
  input  logic                         enable,
  input  logic [SEL_BITS-1:0]          binary_in,
  output logic [n_sel(SEL_BITS)-1:0]   decoder_out
);

  always_comb begin
    decoder_out = '0;
    if (enable) begin
      decoder_out[binary_in] = 1'b1;
    end
  end

endmodule

// File: rtl/io_port_select.sv
// Registered Z80 I/O port selector: qualifies IORQ cycles against BASE_ADDR and
// produces a latched one-hot select, single-clock strobes and programmable WAIT.
module io_port_select
  import io_port_select_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                SEL_BITS    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iorq_n,
  input  logic                         m1_n,
  input  logic                         rd_n,
  input  logic                         wr_n,
  input  logic [ADDR_W-1:0]            addr,
  output logic [n_sel(SEL_BITS)-1:0]   sel_out,
  output logic                         rd_strobe,
  output logic                         wr_strobe,
  output logic                         wait_n,
  output logic                         busy
);

  localparam int N_SEL = n_sel(SEL_BITS);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  if (SEL_BITS < 1 || SEL_BITS >= ADDR_W || WAIT_CYCLES < 0 || WAIT_CYCLES > 15 ||
      BASE_ADDR[SEL_BITS-1:0] != '0) begin : g_bad_params
    $error("io_port_select: illegal SEL_BITS, BASE_ADDR low bits or WAIT_CYCLES");
  end

  state_t              state;
  logic [SEL_BITS-1:0] index_q;
  logic                write_q;
  logic                first_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic [N_SEL-1:0]    decoded;
  logic                request;

  // Bus handshake: a cycle is offered while iorq_n is low with exactly one of
  // rd_n/wr_n low; it is held off by wait_n=0 and ends when iorq_n returns high.
  assign request = !iorq_n && m1_n && (rd_n ^ wr_n) &&
                   (addr[ADDR_W-1:SEL_BITS] == BASE_ADDR[ADDR_W-1:SEL_BITS]);

  assign busy = (state != S_IDLE);

  onehot_decoder #(
    .SEL_BITS (SEL_BITS)
  ) u_decoder (
    .enable      (state == S_DECODE),
    .binary_in   (index_q),
    .decoder_out (decoded)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      index_q   <= '0;
      write_q   <= 1'b0;
      first_q   <= 1'b0;
      wait_cnt  <= '0;
      sel_out   <= '0;
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
      wait_n    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (request) begin
            index_q <= addr[SEL_BITS-1:0];
            write_q <= !wr_n;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (iorq_n) begin
            state <= S_RELEASE;
          end else begin
            sel_out <= decoded;
            wait_n  <= 1'b0;
            first_q <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_WAIT;
            end else begin
              state <= S_ACTIVE;
            end
          end
        end
        S_WAIT: begin
          // An aborted cycle drops WAIT immediately and never strobes.
          if (iorq_n) begin
            wait_n   <= 1'b1;
            wait_cnt <= '0;
            state    <= S_RELEASE;
          end else if (wait_cnt == '0) begin
            state <= S_ACTIVE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_ACTIVE: begin
          wait_n    <= 1'b1;
          rd_strobe <= first_q && !write_q;
          wr_strobe <= first_q && write_q;
          first_q   <= 1'b0;
          if (iorq_n) begin
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          sel_out   <= '0;
          rd_strobe <= 1'b0;
          wr_strobe <= 1'b0;
          wait_n    <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_select.sv
// Bench for io_port_select: four parameter variants share one bus and are
// compared every clock against a timeline model, plus directed vectors.
module tb_io_port_select;

  localparam int NDUT = 4;

  logic       clk;
  logic       reset;
  logic       iorq_n, m1_n, rd_n, wr_n;
  logic [7:0] addr;

  logic [15:0]     sel_a, sel_b, sel_c;
  logic [7:0]      sel_d;
  logic [NDUT-1:0] act_rd, act_wr, act_wait, act_busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // variant parameters: a=default, b=BASE 8'h40, c=WAIT_CYCLES 0, d=SEL_BITS 3
  int         p_sel_bits[NDUT] = '{4, 4, 4, 3};
  logic [7:0] p_base[NDUT]     = '{8'h00, 8'h40, 8'h00, 8'h00};
  int         p_wc[NDUT]       = '{2, 2, 0, 2};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  io_port_select u_a (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .sel_out(sel_a), .rd_strobe(act_rd[0]), .wr_strobe(act_wr[0]),
    .wait_n(act_wait[0]), .busy(act_busy[0])
  );

  io_port_select #(.BASE_ADDR(8'h40)) u_b (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .sel_out(sel_b), .rd_strobe(act_rd[1]), .wr_strobe(act_wr[1]),
    .wait_n(act_wait[1]), .busy(act_busy[1])
  );

  io_port_select #(.WAIT_CYCLES(0)) u_c (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .sel_out(sel_c), .rd_strobe(act_rd[2]), .wr_strobe(act_wr[2]),
    .wait_n(act_wait[2]), .busy(act_busy[2])
  );

  io_port_select #(.SEL_BITS(3)) u_d (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .sel_out(sel_d), .rd_strobe(act_rd[3]), .wr_strobe(act_wr[3]),
    .wait_n(act_wait[3]), .busy(act_busy[3])
  );

  function automatic logic [15:0] get_sel(input int i);
    case (i)
      0:       return sel_a;
      1:       return sel_b;
      2:       return sel_c;
      default: return {8'h00, sel_d};
    endcase
  endfunction

  // Reference model: each access is a timeline counted in edges since the
  // request was accepted (k=0); end_k is the edge where iorq_n was seen high.
  bit m_active[NDUT];
  int m_k[NDUT];
  bit m_ended[NDUT];
  int m_end_k[NDUT];
  int m_idx[NDUT];
  bit m_write[NDUT];

  function automatic bit model_req(input int i);
    int sb;
    sb = p_sel_bits[i];
    return !iorq_n && m1_n && (rd_n != wr_n) &&
           ((int'(addr) >> sb) == (int'(p_base[i]) >> sb));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (reset) begin
        m_active[i] = 0;
        m_k[i]      = 0;
        m_ended[i]  = 0;
      end else if (!m_active[i]) begin
        if (model_req(i)) begin
          m_active[i] = 1;
          m_k[i]      = 0;
          m_ended[i]  = 0;
          m_end_k[i]  = 0;
          m_idx[i]    = int'(addr) % (1 << p_sel_bits[i]);
          m_write[i]  = !wr_n;
        end
      end else begin
        m_k[i] = m_k[i] + 1;
        if (m_ended[i]) begin
          if (m_k[i] == m_end_k[i] + 1) m_active[i] = 0;
        end else if (iorq_n) begin
          m_ended[i] = 1;
          m_end_k[i] = m_k[i];
        end
      end
    end
  end

  // expected {sel, rd_strobe, wr_strobe, wait_n, busy}
  function automatic logic [19:0] model_out(input int i);
    logic [15:0] s;
    logic r, w, wt, b;
    int wc;
    s = '0; r = 0; w = 0; wt = 1; b = 0;
    wc = p_wc[i];
    if (m_active[i]) begin
      b = 1;
      if (m_k[i] >= 1 && !(m_ended[i] && m_end_k[i] == 1)) s = 16'(1) << m_idx[i];
      if (!m_ended[i] && m_k[i] >= 1 && m_k[i] <= 1 + wc) wt = 0;
      if (m_k[i] == 2 + wc && !(m_ended[i] && m_end_k[i] < 2 + wc)) begin
        r = !m_write[i];
        w = m_write[i];
      end
    end
    return {s, r, w, wt, b};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("model_dut%0d_t%0t", i, $time),
            {12'h0, get_sel(i), act_rd[i], act_wr[i], act_wait[i], act_busy[i]},
            {12'h0, model_out(i)});
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) compare_all();
  endtask

  // driver tasks
  int          mon_wait[NDUT], mon_rd[NDUT], mon_wr[NDUT], mon_busy[NDUT];
  logic [15:0] mon_sel[NDUT];

  task automatic sample_mon();
    for (int i = 0; i < NDUT; i++) begin
      mon_wait[i] += int'(!act_wait[i]);
      mon_rd[i]   += int'(act_rd[i]);
      mon_wr[i]   += int'(act_wr[i]);
      mon_busy[i] += int'(act_busy[i]);
      mon_sel[i]  |= get_sel(i);
    end
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic bus_cycle(input logic [7:0] a, input logic r_n, input logic w_n,
                           input logic m1, input int hold);
    for (int i = 0; i < NDUT; i++) begin
      mon_wait[i] = 0; mon_rd[i] = 0; mon_wr[i] = 0; mon_busy[i] = 0; mon_sel[i] = '0;
    end
    addr = a; rd_n = r_n; wr_n = w_n; m1_n = m1; iorq_n = 1'b0;
    for (int c = 0; c < hold; c++) begin
      step();
      sample_mon();
    end
    bus_idle();
    for (int c = 0; c < 4; c++) begin
      step();
      sample_mon();
    end
  endtask

  typedef struct {
    int          dut;
    logic [7:0]  addr;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic [15:0] exp_sel;
    int          exp_wait;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t       tbl[10];
  logic [9:0] tr_wait[NDUT], tr_rd[NDUT];
  logic [15:0] sel_s1[NDUT], sel_s8[NDUT], sel_s9[NDUT];
  int         rd_seen;

  initial begin
    reset = 1'b1;
    addr  = 8'h00;
    bus_idle();
    repeat (3) @(negedge clk);
    check("reset_sel", {16'h0, sel_a}, 32'h0);
    check("reset_rd", {31'h0, act_rd[0]}, 32'h0);
    check("reset_wr", {31'h0, act_wr[0]}, 32'h0);
    check("reset_wait_n", {31'h0, act_wait[0]}, 32'h1);
    check("reset_busy", {31'h0, act_busy[0]}, 32'h0);
    chk_en = 1;
    reset  = 1'b0;
    step();

    // table-driven single accesses
    tbl[0] = '{0, 8'h05, 1'b0, 1'b1, 1'b1, 16'h0020, 3, 1, 0};
    tbl[1] = '{0, 8'h0F, 1'b1, 1'b0, 1'b1, 16'h8000, 3, 0, 1};
    tbl[2] = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h0001, 3, 1, 0};
    tbl[3] = '{0, 8'h03, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0, 0};
    tbl[4] = '{0, 8'h03, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 0, 0};
    tbl[5] = '{0, 8'h15, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 0, 0};
    tbl[6] = '{1, 8'h4F, 1'b1, 1'b0, 1'b1, 16'h8000, 3, 0, 1};
    tbl[7] = '{1, 8'h5F, 1'b1, 1'b0, 1'b1, 16'h0000, 0, 0, 0};
    tbl[8] = '{2, 8'h05, 1'b0, 1'b1, 1'b1, 16'h0020, 1, 1, 0};
    tbl[9] = '{3, 8'h05, 1'b0, 1'b1, 1'b1, 16'h0020, 3, 1, 0};
    for (int v = 0; v < 10; v++) begin
      bus_cycle(tbl[v].addr, tbl[v].rd_n, tbl[v].wr_n, tbl[v].m1_n, 8);
      check($sformatf("vec%0d_sel", v), {16'h0, mon_sel[tbl[v].dut]}, {16'h0, tbl[v].exp_sel});
      check($sformatf("vec%0d_wait_clocks", v), mon_wait[tbl[v].dut], tbl[v].exp_wait);
      check($sformatf("vec%0d_rd_pulses", v), mon_rd[tbl[v].dut], tbl[v].exp_rd);
      check($sformatf("vec%0d_wr_pulses", v), mon_wr[tbl[v].dut], tbl[v].exp_wr);
      check($sformatf("vec%0d_busy_seen", v), {31'h0, mon_busy[tbl[v].dut] != 0},
            {31'h0, tbl[v].exp_wait != 0});
    end

    // read 8'h05: exact wait/strobe/select timing per edge
    addr = 8'h05; rd_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      for (int i = 0; i < NDUT; i++) begin
        tr_wait[i][s] = act_wait[i];
        tr_rd[i][s]   = act_rd[i];
        if (s == 1) sel_s1[i] = get_sel(i);
        if (s == 8) sel_s8[i] = get_sel(i);
        if (s == 9) sel_s9[i] = get_sel(i);
      end
      if (s == 7) bus_idle();
    end
    check("seq_a_wait_trace", {22'h0, tr_wait[0]}, 32'h3F1);
    check("seq_a_rd_trace", {22'h0, tr_rd[0]}, 32'h010);
    check("seq_a_sel_valid", {16'h0, sel_s1[0]}, 32'h0020);
    check("seq_a_sel_held", {16'h0, sel_s8[0]}, 32'h0020);
    check("seq_a_sel_cleared", {16'h0, sel_s9[0]}, 32'h0);
    check("seq_b_wait_trace", {22'h0, tr_wait[1]}, 32'h3FF);
    check("seq_c_wait_trace", {22'h0, tr_wait[2]}, 32'h3FD);
    check("seq_c_rd_trace", {22'h0, tr_rd[2]}, 32'h004);
    check("seq_d_sel_valid", {16'h0, sel_s1[3]}, 32'h0020);
    check("seq_d_wait_trace", {22'h0, tr_wait[3]}, 32'h3F1);
    repeat (3) step();

    // abort while in WAIT, then a normal access must still be accepted
    addr = 8'h05; rd_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b0;
    step();
    step();
    check("abort_wait_low", {31'h0, act_wait[0]}, 32'h0);
    bus_idle();
    rd_seen = 0;
    for (int s = 2; s < 7; s++) begin
      step();
      rd_seen += int'(act_rd[0]);
      if (s == 2) check("abort_wait_released", {31'h0, act_wait[0]}, 32'h1);
      if (s == 3) begin
        check("abort_sel_cleared", {16'h0, sel_a}, 32'h0);
        check("abort_busy_cleared", {31'h0, act_busy[0]}, 32'h0);
      end
    end
    check("abort_no_strobe", rd_seen, 0);
    bus_cycle(8'h05, 1'b0, 1'b1, 1'b1, 8);
    check("after_abort_rd", mon_rd[0], 1);
    check("after_abort_sel", {16'h0, mon_sel[0]}, 32'h0020);

    // reset while ACTIVE with sel 16'h0004
    addr = 8'h02; rd_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b0;
    repeat (6) step();
    check("active_sel", {16'h0, sel_a}, 32'h0004);
    check("active_busy", {31'h0, act_busy[0]}, 32'h1);
    reset = 1'b1;
    step();
    check("rst_active_sel", {16'h0, sel_a}, 32'h0);
    check("rst_active_wait_n", {31'h0, act_wait[0]}, 32'h1);
    check("rst_active_busy", {31'h0, act_busy[0]}, 32'h0);
    check("rst_active_strobes", {30'h0, act_rd[0], act_wr[0]}, 32'h0);
    reset = 1'b0;
    bus_idle();
    repeat (3) step();

    // randomized traffic against the model
    for (int t = 0; t < 250; t++) begin
      int kind;
      int hold;
      kind = int'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0:       addr = 8'($urandom_range(0, 255));
        1:       addr = {4'h0, 4'($urandom_range(0, 15))};
        2:       addr = {4'h4, 4'($urandom_range(0, 15))};
        default: addr = {5'h00, 3'($urandom_range(0, 7))};
      endcase
      m1_n = (kind == 3) ? 1'b0 : 1'b1;
      rd_n = (kind == 2 || kind == 5) ? 1'b1 : 1'b0;
      wr_n = (kind == 2 || kind == 4 || kind == 5) ? 1'b0 : 1'b1;
      iorq_n = 1'b0;
      hold = int'($urandom_range(1, 8));
      for (int h = 0; h < hold; h++) begin
        step();
        if ($urandom_range(0, 3) == 0) addr = 8'($urandom_range(0, 255));
      end
      bus_idle();
      repeat (int'($urandom_range(1, 4))) step();
    end

    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
